// File: rtl/multiplicador_booth.sv
// multiplicador_booth: sequential radix-2 Booth multiplier.
// The operands are widened to W = N+1 bits. The accumulator A, the multiplier
// register Q and the qsub1 bit step through W add/subtract + shift pairs.
// The 2N-bit product is registered on resultado, and Fin pulses for one cycle
// when the product is ready.
// Optional macro MULT_UNSIGNED_EN adds the sin_signo input, which selects
// zero-extension (unsigned product) instead of sign-extension.

module multiplicador_booth #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           inicio,
    input  logic [N-1:0]   multiplicando,
    input  logic [N-1:0]   multiplicador,
`ifdef MULT_UNSIGNED_EN
    input  logic           sin_signo,
`endif
    output logic [2*N-1:0] resultado,
    output logic           ocupado,
    output logic           Fin
);

    localparam int W  = N + 1;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        OPERA,
        DESPLAZA,
        FIN
    } estado_t;

    estado_t        estado;
    estado_t        siguiente;
    logic [W-1:0]   a;
    logic [W-1:0]   q;
    logic [W-1:0]   m;
    logic           qsub1;
    logic [CW-1:0]  cuenta;
    logic           ext_m;
    logic           ext_q;
    logic [W-1:0]   a_op;
    logic [2*W-1:0] desplazado;

    // Extension bit used to widen each operand to W bits at load time
    always_comb begin
`ifdef MULT_UNSIGNED_EN
        ext_m = sin_signo ? 1'b0 : multiplicando[N-1];
        ext_q = sin_signo ? 1'b0 : multiplicador[N-1];
`else
        ext_m = multiplicando[N-1];
        ext_q = multiplicador[N-1];
`endif
    end

    // Booth recoding of {Q[0], qsub1}: add M, subtract M, or keep A (modulo 2^W)
    always_comb begin
        a_op = a;
        case ({q[0], qsub1})
            2'b01:   a_op = a + m;
            2'b10:   a_op = a - m;
            default: a_op = a;
        endcase
    end

    // {A,Q} arithmetic-shifted right by one bit, with the A sign bit replicated
    assign desplazado = {a[W-1], a, q[W-1:1]};

    // State register, with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= siguiente;
        end
    end

    // Next-state logic and the state-decoded outputs
    always_comb begin
        siguiente = estado;
        ocupado   = 1'b1;
        Fin       = 1'b0;
        case (estado)
            IDLE: begin
                ocupado = 1'b0;
                if (inicio) begin
                    siguiente = OPERA;
                end
            end
            OPERA: begin
                siguiente = DESPLAZA;
            end
            DESPLAZA: begin
                if (cuenta == CW'(1)) begin
                    siguiente = FIN;
                end else begin
                    siguiente = OPERA;
                end
            end
            FIN: begin
                Fin       = 1'b1;
                siguiente = IDLE;
            end
            default: begin
                siguiente = IDLE;
            end
        endcase
    end

    // Datapath. The product is captured on the final shift so that it is
    // already visible on resultado during the Fin cycle. It then holds until
    // the next operation completes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a         <= '0;
            q         <= '0;
            m         <= '0;
            qsub1     <= 1'b0;
            cuenta    <= '0;
            resultado <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (inicio) begin
                        a      <= '0;
                        qsub1  <= 1'b0;
                        cuenta <= CW'(W);
                        m      <= {ext_m, multiplicando};
                        q      <= {ext_q, multiplicador};
                    end
                end
                OPERA: begin
                    a <= a_op;
                end
                DESPLAZA: begin
                    a      <= desplazado[2*W-1:W];
                    q      <= desplazado[W-1:0];
                    qsub1  <= q[0];
                    cuenta <= cuenta - CW'(1);
                    if (cuenta == CW'(1)) begin
                        resultado <= desplazado[2*N-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_booth.sv
// tb_multiplicador_booth: self-checking bench for multiplicador_booth.
// Two instances are used, with N=3 and N=8. A table of directed vectors is
// run, then hand-written busy-inicio and reset-abort sequences, then random
// operands checked against an arithmetic product model.

module tb_multiplicador_booth;

    typedef struct {
        string       name;
        int          n;
        logic [7:0]  m;
        logic [7:0]  q;
        bit          uns;
        logic [15:0] expd;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        inicio3;
    logic        inicio8;
    logic [2:0]  m3;
    logic [2:0]  q3;
    logic [7:0]  m8;
    logic [7:0]  q8;
    logic [5:0]  res3;
    logic [15:0] res8;
    logic        ocu3;
    logic        ocu8;
    logic        fin3;
    logic        fin8;
`ifdef MULT_UNSIGNED_EN
    logic        sin3;
    logic        sin8;
`endif

    int          compared;
    int          failed;
    logic [15:0] lastExp3;
    logic [15:0] lastExp8;
    vec_t        vecs[$];

    multiplicador_booth #(.N(3)) dut3 (
        .clk           (clk),
        .reset         (reset),
        .inicio        (inicio3),
        .multiplicando (m3),
        .multiplicador (q3),
`ifdef MULT_UNSIGNED_EN
        .sin_signo     (sin3),
`endif
        .resultado     (res3),
        .ocupado       (ocu3),
        .Fin           (fin3)
    );

    multiplicador_booth #(.N(8)) dut8 (
        .clk           (clk),
        .reset         (reset),
        .inicio        (inicio8),
        .multiplicando (m8),
        .multiplicador (q8),
`ifdef MULT_UNSIGNED_EN
        .sin_signo     (sin8),
`endif
        .resultado     (res8),
        .ocupado       (ocu8),
        .Fin           (fin8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Safety net so the run always terminates on its own
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference product: interpret the operands as n-bit signed or unsigned
    // integers, multiply them, and keep the low 2n bits.
    function automatic logic [15:0] refProd(input int n, input logic [7:0] mm,
                                            input logic [7:0] qq, input bit uns);
        longint span;
        longint av;
        longint bv;
        longint p;
        span = longint'(1) << n;
        av   = longint'(mm) & (span - 1);
        bv   = longint'(qq) & (span - 1);
        if (!uns && av >= span / 2) av = av - span;
        if (!uns && bv >= span / 2) bv = bv - span;
        p = av * bv;
        return 16'(p & (span * span - 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Called at a negedge with the selected DUT idle. Starts one operation,
    // follows it for a bounded number of cycles, and checks latency, the Fin
    // pulse count, the product and that resultado holds. If molestar is set,
    // inicio is held high and the operands are scrambled while the DUT is busy.
    task automatic applyStimulus(input int n, input logic [7:0] mm, input logic [7:0] qq,
                                 input bit uns, input bit molestar,
                                 input logic [15:0] expd, input string tag);
        int          w;
        int          limit;
        int          finCount;
        int          finCycle;
        logic [15:0] resFin;
        logic [15:0] res;
        logic [15:0] prevExp;
        logic        fin;
        logic        ocu;
        w        = n + 1;
        limit    = 2 * w + 4;
        finCount = 0;
        finCycle = -1;
        resFin   = '0;
        res      = '0;
        ocu      = 1'b0;
        prevExp  = (n == 3) ? lastExp3 : lastExp8;
        if (n == 3) begin
            inicio3 = 1'b1;
            m3      = mm[2:0];
            q3      = qq[2:0];
`ifdef MULT_UNSIGNED_EN
            sin3    = uns;
`endif
        end else begin
            inicio8 = 1'b1;
            m8      = mm;
            q8      = qq;
`ifdef MULT_UNSIGNED_EN
            sin8    = uns;
`endif
        end
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            fin = (n == 3) ? fin3 : fin8;
            ocu = (n == 3) ? ocu3 : ocu8;
            res = (n == 3) ? {10'b0, res3} : res8;
            if (k == 1) checkOutput({tag, " ocupado"}, 32'(ocu), 32'd1);
            if (k == w) checkOutput({tag, " hold_prev"}, 32'(res), 32'(prevExp));
            if (fin) begin
                finCount++;
                if (finCycle < 0) begin
                    finCycle = k;
                    resFin   = res;
                end
            end
            if (n == 3) begin
                inicio3 = molestar && ocu && (k < limit);
                if (molestar) begin
                    m3 = 3'($urandom);
                    q3 = 3'($urandom);
                end
            end else begin
                inicio8 = molestar && ocu && (k < limit);
                if (molestar) begin
                    m8 = 8'($urandom);
                    q8 = 8'($urandom);
                end
            end
        end
        checkOutput({tag, " fin_count"}, 32'(finCount), 32'd1);
        checkOutput({tag, " latency"}, 32'(finCycle), 32'(2 * w + 1));
        checkOutput({tag, " product"}, 32'(resFin), 32'(expd));
        checkOutput({tag, " hold_after"}, 32'(res), 32'(expd));
        checkOutput({tag, " idle"}, 32'(ocu), 32'd0);
        if (n == 3) lastExp3 = expd;
        else        lastExp8 = expd;
    endtask

    initial begin
        int          abortFins;
        int          n;
        logic [7:0]  mm;
        logic [7:0]  qq;
        bit          uns;
        bit          mol;

        compared = 0;
        failed   = 0;
        lastExp3 = '0;
        lastExp8 = '0;
        reset    = 1'b0;
        inicio3  = 1'b0;
        inicio8  = 1'b0;
        m3 = '0; q3 = '0; m8 = '0; q8 = '0;
`ifdef MULT_UNSIGNED_EN
        sin3 = 1'b0;
        sin8 = 1'b0;
`endif

        vecs.push_back('{"n3_3x-2",     3, 8'h03, 8'h06, 1'b0, 16'h003A});
        vecs.push_back('{"n3_-4x-4",    3, 8'h04, 8'h04, 1'b0, 16'h0010});
        vecs.push_back('{"n3_-4x3",     3, 8'h04, 8'h03, 1'b0, 16'h0034});
        vecs.push_back('{"n8_127x-128", 8, 8'h7F, 8'h80, 1'b0, 16'hC080});
        vecs.push_back('{"n8_-128x-128",8, 8'h80, 8'h80, 1'b0, 16'h4000});
        vecs.push_back('{"n8_-1x-1",    8, 8'hFF, 8'hFF, 1'b0, 16'h0001});
        vecs.push_back('{"n8_0x90",     8, 8'h00, 8'h5A, 1'b0, 16'h0000});
        vecs.push_back('{"n8_12x-7",    8, 8'h0C, 8'hF9, 1'b0, 16'hFFAC});
`ifdef MULT_UNSIGNED_EN
        vecs.push_back('{"n3_u7x7",     3, 8'h07, 8'h07, 1'b1, 16'h0031});
        vecs.push_back('{"n3_s7x7",     3, 8'h07, 8'h07, 1'b0, 16'h0001});
        vecs.push_back('{"n8_u255x255", 8, 8'hFF, 8'hFF, 1'b1, 16'hFE01});
`endif

        // Hold reset for two edges and check the reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset res3", 32'(res3), 32'd0);
        checkOutput("reset res8", 32'(res8), 32'd0);
        checkOutput("reset fin", 32'({fin3, fin8}), 32'd0);
        checkOutput("reset ocupado", 32'({ocu3, ocu8}), 32'd0);

        // The first inicio arrives in the first cycle with reset released
        reset = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].n, vecs[i].m, vecs[i].q, vecs[i].uns, 1'b0,
                          vecs[i].expd, vecs[i].name);
        end

        // inicio is held high and the operands change while the DUT is busy
        applyStimulus(3, 8'h03, 8'h06, 1'b0, 1'b1, 16'h003A, "busy_n3");
        applyStimulus(8, 8'h7F, 8'h80, 1'b0, 1'b1, 16'hC080, "busy_n8");

        // Reset asserted during the third OPERA cycle aborts the operation
        abortFins = 0;
        inicio8   = 1'b1;
        m8        = 8'h55;
        q8        = 8'h33;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            inicio8 = 1'b0;
            if (fin8) abortFins++;
            if (k == 5) reset = 1'b0;
        end
        @(negedge clk);
        checkOutput("abort res8", 32'(res8), 32'd0);
        checkOutput("abort res3", 32'(res3), 32'd0);
        checkOutput("abort fin", 32'({fin3, fin8}), 32'd0);
        checkOutput("abort ocupado", 32'({ocu3, ocu8}), 32'd0);
        reset    = 1'b1;
        lastExp3 = '0;
        lastExp8 = '0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk);
            if (fin8) abortFins++;
        end
        checkOutput("abort no_fin", 32'(abortFins), 32'd0);
        applyStimulus(8, 8'h55, 8'h33, 1'b0, 1'b0, refProd(8, 8'h55, 8'h33, 1'b0), "after_abort");

        // Random operands checked against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            n   = ($urandom_range(0, 1) == 0) ? 3 : 8;
            mm  = 8'($urandom);
            qq  = 8'($urandom);
            mol = ($urandom_range(0, 3) == 0);
            uns = 1'b0;
`ifdef MULT_UNSIGNED_EN
            uns = 1'($urandom_range(0, 1));
`endif
            applyStimulus(n, mm, qq, uns, mol, refProd(n, mm, qq, uns),
                          $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/multiplicador_booth.md
MULTIPLICADOR_BOOTH -- requirements
Module: multiplicador_booth

Interface
REQ-001 SHALL have parameter: N, default 8, operand width in bits (N >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: inicio  input  1  start request; sampled only in IDLE.
REQ-005 SHALL have port: multiplicando  input  N  operand M.
REQ-006 SHALL have port: multiplicador  input  N  operand Q.
REQ-007 SHALL have port: resultado  output  2N  product, registered.
REQ-008 SHALL have port: ocupado  output  1  high in every state except IDLE.
REQ-009 SHALL have port: Fin  output  1  one-cycle completion pulse.

Function
REQ-010 SHALL implement radix-2 Booth multiplication on an internal width W = N+1: accumulator A[W], register Q[W], register M[W], bit qsub1, iteration counter.
REQ-011 SHALL have FSM states IDLE, OPERA, DESPLAZA, FIN.
REQ-012 IDLE with inicio=1 at cycle T SHALL, on that edge, load A=0, qsub1=0, counter=W, and sign-extend both operands into M and Q; next state OPERA.
REQ-013 OPERA SHALL use {Q[0],qsub1}: 01 -> A=A+M; 10 -> A=A-M; 00/11 -> A unchanged; arithmetic is modulo 2^W; next state DESPLAZA.
REQ-014 DESPLAZA SHALL arithmetic-shift {A,Q,qsub1} right by one bit (A MSB replicated) and decrement the counter; next state OPERA if counter != 0 after decrement, else FIN.
REQ-015 FIN SHALL drive Fin=1 for exactly one cycle, load resultado with the low 2N bits of {A,Q}, and return to IDLE.
REQ-016 Latency SHALL be fixed: Fin high in cycle T+2W+1 (N=3: T+9; N=8: T+19), independent of operand values.
REQ-017 resultado SHALL hold its value from FIN until the next FIN; it SHALL NOT show intermediate values.
REQ-018 inicio SHALL be ignored while ocupado=1, including during FIN; operand changes after cycle T SHALL have no effect.
REQ-019 The most negative operand (-2^(N-1)) in either or both positions SHALL produce the exact 2N-bit two's-complement product.

Reset
REQ-020 reset=0 at a rising edge SHALL force state IDLE, A=Q=M=0, qsub1=0, counter=0, resultado=0, Fin=0, ocupado=0.
REQ-021 Reset SHALL take priority over inicio and over any in-progress operation; the aborted operation produces no Fin.
REQ-022 The first inicio is accepted in the first cycle with reset=1.

Configuration
REQ-023 Macro MULT_UNSIGNED_EN, when defined, SHALL add input port sin_signo (1 bit), sampled with the operands at cycle T.
REQ-024 With MULT_UNSIGNED_EN: sin_signo=1 SHALL zero-extend both operands to W (unsigned product); sin_signo=0 SHALL sign-extend (signed product); latency is unchanged.
REQ-025 Without MULT_UNSIGNED_EN: port sin_signo SHALL be absent and all operands are treated as signed.

Verification
REQ-026 N=3, M=3'b011 (3), Q=3'b110 (-2), inicio at T -> Fin high in cycle T+9 only, resultado=6'b111010 (-6).
REQ-027 N=3, M=Q=3'b100 (-4) -> resultado=6'b010000 (16); N=8, M=127, Q=-128 -> resultado=16'hC080 (-16256) in cycle T+19.
REQ-028 MULT_UNSIGNED_EN, N=3, sin_signo=1, M=Q=3'b111 -> resultado=6'b110001 (49); with sin_signo=0, same operands -> 6'b000001.
REQ-029 Start a multiply, then pulse inicio every cycle while ocupado=1 and change the operands -> exactly one Fin, product of the originally sampled operands.
REQ-030 reset=0 in the third OPERA cycle -> next cycle all outputs 0, state IDLE, no Fin; a new inicio then completes normally in 2W+1 cycles.
